// File: rtl/cpu_pkg.sv
// Shared definitions for the moxie pipeline register scoreboard.
`ifndef CPU_PKG_SV
`define CPU_PKG_SV

// Selects read port r out of a packed vector of w-bit fields.
`define CPU_RD_SLICE(vec, r, w) vec[(r)*(w) +: (w)]

package cpu_pkg;
    localparam int CPU_IDX_W    = 4;
    localparam int CPU_NREGS    = 16;
    localparam int CPU_SB_CNT_W = 2;
endpackage

`endif

// File: rtl/cpu_scoreboard_port.sv
// One scoreboard read port: hazard detection and execute-stage bypass select.
module cpu_scoreboard_port
    import cpu_pkg::*;
#(
    parameter int IDX_W   = CPU_IDX_W,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = CPU_SB_CNT_W,
    parameter int FORWARD = 1
) (
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [CNT_W-1:0]  pend,
    input  logic              ex_valid,
    input  logic [IDX_W-1:0]  ex_wr_idx,
    input  logic [DATA_W-1:0] ex_result,
    output logic              blocked,
    output logic              fwd_sel,
    output logic [DATA_W-1:0] fwd_data
);

    logic forwardable;

    // A single outstanding write that is sitting in execute is the youngest
    // value, so it can be bypassed; anything deeper must wait.
    always_comb begin
        forwardable = (FORWARD != 0) && ex_valid && (ex_wr_idx == rd_idx)
                      && (pend == CNT_W'(1));
        blocked     = rd_en && (pend != '0) && !forwardable;
        fwd_sel     = rd_en && forwardable;
        fwd_data    = fwd_sel ? ex_result : '0;
    end

endmodule

// File: rtl/cpu_scoreboard.sv
// Register-hazard scoreboard with per-register pending-write counters.
module cpu_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREGS   = CPU_NREGS,
    parameter int IDX_W   = CPU_IDX_W,
    parameter int NREAD   = 2,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = CPU_SB_CNT_W,
    parameter int FORWARD = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    issue_valid_i,
    input  logic                    issue_wr_en_i,
    input  logic [IDX_W-1:0]        issue_wr_idx_i,
    input  logic [NREAD-1:0]        issue_rd_en_i,
    input  logic [NREAD*IDX_W-1:0]  issue_rd_idx_i,
    input  logic                    ex_valid_i,
    input  logic [IDX_W-1:0]        ex_wr_idx_i,
    input  logic [DATA_W-1:0]       ex_result_i,
    input  logic                    wb_valid_i,
    input  logic [IDX_W-1:0]        wb_idx_i,
    input  logic                    flush_i,
    output logic                    stall_o,
    output logic [NREAD-1:0]        fwd_sel_o,
    output logic [NREAD*DATA_W-1:0] fwd_data_o,
    output logic [NREGS-1:0]        busy_o,
    output logic [15:0]             stall_cycles_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] pending [NREGS];
    logic [15:0]      stall_cycles;
    logic [NREAD-1:0] blocked;
    logic [CNT_W-1:0] pend_wr, pend_wb;
    logic             wr_in_range, wb_in_range, saturated, accept, inc_en, dec_en;
    logic [NREGS-1:0] inc_vec, dec_vec;

    for (genvar r = 0; r < NREAD; r++) begin : g_port
        logic [IDX_W-1:0] idx;
        logic [CNT_W-1:0] pend;

        assign idx  = `CPU_RD_SLICE(issue_rd_idx_i, r, IDX_W);
        assign pend = (int'(idx) < NREGS) ? pending[idx] : '0;

        cpu_scoreboard_port #(
            .IDX_W   (IDX_W),
            .DATA_W  (DATA_W),
            .CNT_W   (CNT_W),
            .FORWARD (FORWARD)
        ) u_port (
            .rd_en     (issue_rd_en_i[r]),
            .rd_idx    (idx),
            .pend      (pend),
            .ex_valid  (ex_valid_i),
            .ex_wr_idx (ex_wr_idx_i),
            .ex_result (ex_result_i),
            .blocked   (blocked[r]),
            .fwd_sel   (fwd_sel_o[r]),
            .fwd_data  (`CPU_RD_SLICE(fwd_data_o, r, DATA_W))
        );
    end

    // Issue handshake: a retiring write to the same register frees one slot,
    // so a full counter only stalls when nothing is leaving this cycle.
    always_comb begin
        wr_in_range = int'(issue_wr_idx_i) < NREGS;
        wb_in_range = int'(wb_idx_i) < NREGS;
        pend_wr     = wr_in_range ? pending[issue_wr_idx_i] : '0;
        pend_wb     = wb_in_range ? pending[wb_idx_i] : '0;
        saturated   = issue_wr_en_i && wr_in_range && (pend_wr == CNT_MAX)
                      && !(wb_valid_i && (wb_idx_i == issue_wr_idx_i));
        stall_o     = issue_valid_i && !flush_i && ((|blocked) || saturated);
        accept      = issue_valid_i && !stall_o && !flush_i;
        inc_en      = accept && issue_wr_en_i && wr_in_range;
        dec_en      = wb_valid_i && !flush_i && wb_in_range;
        for (int i = 0; i < NREGS; i++) begin
            inc_vec[i] = inc_en && (int'(issue_wr_idx_i) == i);
            dec_vec[i] = dec_en && (int'(wb_idx_i) == i);
        end
    end

    // Pending-write counters; a decrement at zero holds rather than wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NREGS; i++) pending[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < NREGS; i++) pending[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                case ({inc_vec[i], dec_vec[i]})
                    2'b10:   pending[i] <= pending[i] + CNT_W'(1);
                    2'b01:   if (pending[i] != '0) pending[i] <= pending[i] - CNT_W'(1);
                    default: pending[i] <= pending[i];
                endcase
            end
        end
    end

    // Saturating stall counter, survives flush.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            stall_cycles <= '0;
        else if (stall_o && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
    end

    // Busy view of the counters.
    always_comb begin
        for (int i = 0; i < NREGS; i++) busy_o[i] = (pending[i] != '0);
    end

    assign stall_cycles_o = stall_cycles;

`ifndef SYNTHESIS
    // Flags writebacks that arrive with nothing pending on that register.
    always @(posedge clk_i) begin
        if (rst_i && dec_en && (pend_wb == '0))
            $display("SCOREBOARD underflow 0x%x", wb_idx_i);
    end
`endif

endmodule
